mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port `memory` block. It shares the memory between the instruction-fetch port (IF, read-only) and the data port (DM, load/store). It registers each granted request, drives `MemRead`/`MemWrite`/`MemAddress`/`WriteData` for exactly one access cycle, and returns read data to the winning requester with a one-cycle valid pulse. Misaligned data accesses are rejected without touching memory.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, port ids and helpers for mem_arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester ports plus memory-side bus of mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_err;

  logic                  busy;

  logic                  MemRead;
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] MemAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic [DATA_WIDTH-1:0] ReadData;

  // Requesters and the memory model sit on the master side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ReadData,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err, busy,
    input  MemRead, MemWrite, MemAddress, WriteData
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ReadData,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, dm_err, busy,
    output MemRead, MemWrite, MemAddress, WriteData
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way winner select, round-robin or DM-priority
module rr_arbiter2
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       valid_o,
  output logic       winner_o
);

  always_comb begin
    valid_o  = |req_i;
    winner_o = PORT_IF;
    if (req_i == 2'b11) begin
      winner_o = (FIXED_PRIO != 0) ? PORT_DM : ~last_grant_i;
    end else if (req_i[PORT_DM]) begin
      winner_o = PORT_DM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between fetch and data ports
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  arb_state_e            state_q;
  logic                  last_grant_q;
  logic                  port_q;
  logic                  we_q;
  logic                  if_gnt_q, dm_gnt_q, if_rvalid_q, dm_rvalid_q, dm_err_q;
  logic                  mem_read_q, mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, dm_rdata_q;

  logic                  arb_valid, arb_winner;
  logic                  sel_we, sel_misaligned;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
    .req_i        ({bus.dm_req, bus.if_req}),
    .last_grant_i (last_grant_q),
    .valid_o      (arb_valid),
    .winner_o     (arb_winner)
  );

  // Fetches are forced to loads and never alignment-checked.
  always_comb begin
    sel_we         = (arb_winner == PORT_DM) && bus.dm_we;
    sel_addr       = (arb_winner == PORT_DM) ? bus.dm_addr : bus.if_addr;
    sel_wdata      = sel_we ? bus.dm_wdata : '0;
    sel_misaligned = (arb_winner == PORT_DM) && is_misaligned(bus.dm_addr[1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DM;
      port_q       <= PORT_IF;
      we_q         <= 1'b0;
      if_gnt_q     <= 1'b0;
      dm_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      dm_err_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      write_data_q <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      // Every output except rdata is a one-state pulse; clear by default.
      if_gnt_q     <= 1'b0;
      dm_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      dm_rvalid_q  <= 1'b0;
      dm_err_q     <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      write_data_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            last_grant_q <= arb_winner;
            port_q       <= arb_winner;
            we_q         <= sel_we;
            if (sel_misaligned) begin
              state_q  <= ERR;
              dm_gnt_q <= 1'b1;
              dm_err_q <= 1'b1;
            end else begin
              state_q      <= ACCESS;
              if_gnt_q     <= (arb_winner == PORT_IF);
              dm_gnt_q     <= (arb_winner == PORT_DM);
              mem_read_q   <= ~sel_we;
              mem_write_q  <= sel_we;
              mem_addr_q   <= sel_addr;
              write_data_q <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            state_q <= IDLE;
          end else begin
            state_q <= RESP;
            if (port_q == PORT_DM) begin
              dm_rdata_q  <= bus.ReadData;
              dm_rvalid_q <= 1'b1;
            end else begin
              if_rdata_q  <= bus.ReadData;
              if_rvalid_q <= 1'b1;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_gnt     = if_gnt_q;
  assign bus.dm_gnt     = dm_gnt_q;
  assign bus.if_rvalid  = if_rvalid_q;
  assign bus.dm_rvalid  = dm_rvalid_q;
  assign bus.dm_err     = dm_err_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.dm_rdata   = dm_rdata_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.MemRead    = mem_read_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.MemAddress = mem_addr_q;
  assign bus.WriteData  = write_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter (round-robin and fixed priority)
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(0)) dut_rr (.clk(clk), .reset(reset), .bus(bus0));
  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1)) dut_fp (.clk(clk), .reset(reset), .bus(bus1));

  // Memory models: words 0 and 1 are fixed ROM, everything else is RAM.
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  function automatic logic [31:0] rom_or(input logic [7:0] widx, input logic [31:0] ram);
    if (widx == 8'd0) return 32'h0000_0013;
    if (widx == 8'd1) return 32'h00A0_0093;
    return ram;
  endfunction

  assign bus0.ReadData = rom_or(bus0.MemAddress[9:2], mem0[bus0.MemAddress[9:2]]);
  assign bus1.ReadData = rom_or(bus1.MemAddress[9:2], mem1[bus1.MemAddress[9:2]]);

  always @(posedge clk) begin
    if (bus0.MemWrite) mem0[bus0.MemAddress[9:2]] <= bus0.WriteData;
    if (bus1.MemWrite) mem1[bus1.MemAddress[9:2]] <= bus1.WriteData;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_reqs();
    bus0.if_req = 1'b0; bus0.dm_req = 1'b0;
    bus1.if_req = 1'b0; bus1.dm_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) begin
      if (!bus0.busy && !bus1.busy) break;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus0.if_req = 1'b1; bus0.if_addr = 32'h0; bus0.dm_req = 1'b1; bus0.dm_we = 1'b0;
    bus0.dm_addr = 32'h40; bus0.dm_wdata = 32'h0;
    bus1.if_req = 1'b1; bus1.if_addr = 32'h0; bus1.dm_req = 1'b1; bus1.dm_we = 1'b0;
    bus1.dm_addr = 32'h40; bus1.dm_wdata = 32'h0;
    step(); step();
    checks++; if ({bus0.if_gnt, bus0.dm_gnt, bus0.if_rvalid, bus0.dm_rvalid, bus0.dm_err, bus0.busy, bus0.MemRead, bus0.MemWrite} !== 8'h00) begin errors++; $display("FAIL reset_flags: got %b want 00000000", {bus0.if_gnt, bus0.dm_gnt, bus0.if_rvalid, bus0.dm_rvalid, bus0.dm_err, bus0.busy, bus0.MemRead, bus0.MemWrite}); end
    checks++; if ({bus0.MemAddress, bus0.WriteData, bus0.if_rdata, bus0.dm_rdata} !== 128'h0) begin errors++; $display("FAIL reset_buses: got %h want 0", {bus0.MemAddress, bus0.WriteData, bus0.if_rdata, bus0.dm_rdata}); end
    checks++; if ({bus1.dm_gnt, bus1.busy, bus1.MemRead} !== 3'b000) begin errors++; $display("FAIL reset_fp: got %b want 000", {bus1.dm_gnt, bus1.busy, bus1.MemRead}); end
    reset = 1'b0;
    step();
    checks++; if ({bus0.if_gnt, bus0.dm_gnt} !== 2'b10) begin errors++; $display("FAIL first_tie_rr: got if/dm gnt %b want 10", {bus0.if_gnt, bus0.dm_gnt}); end
    checks++; if ({bus1.if_gnt, bus1.dm_gnt} !== 2'b01) begin errors++; $display("FAIL first_tie_fp: got if/dm gnt %b want 01", {bus1.if_gnt, bus1.dm_gnt}); end
    drop_reqs();
    wait_idle();
  endtask

  task automatic test_if_read();
    bus0.if_req = 1'b1; bus0.if_addr = 32'h0;
    step();
    checks++; if ({bus0.if_gnt, bus0.dm_gnt, bus0.MemRead, bus0.MemWrite, bus0.busy} !== 5'b10101) begin errors++; $display("FAIL if_read_access: got gnt/gnt/rd/wr/busy %b want 10101", {bus0.if_gnt, bus0.dm_gnt, bus0.MemRead, bus0.MemWrite, bus0.busy}); end
    checks++; if (bus0.MemAddress !== 32'h0) begin errors++; $display("FAIL if_read_addr: got %h want 00000000", bus0.MemAddress); end
    bus0.if_req = 1'b0;
    step();
    checks++; if ({bus0.if_rvalid, bus0.if_gnt, bus0.MemRead} !== 3'b100) begin errors++; $display("FAIL if_read_resp: got rvalid/gnt/rd %b want 100", {bus0.if_rvalid, bus0.if_gnt, bus0.MemRead}); end
    checks++; if (bus0.if_rdata !== 32'h0000_0013) begin errors++; $display("FAIL if_read_data: got %h want 00000013", bus0.if_rdata); end
    step();
    checks++; if ({bus0.if_rvalid, bus0.busy} !== 2'b00) begin errors++; $display("FAIL if_read_done: got rvalid/busy %b want 00", {bus0.if_rvalid, bus0.busy}); end
  endtask

  task automatic test_store_load();
    bus0.dm_req = 1'b1; bus0.dm_we = 1'b1; bus0.dm_addr = 32'h40; bus0.dm_wdata = 32'hDEAD_BEEF;
    step();
    checks++; if ({bus0.dm_gnt, bus0.MemWrite, bus0.MemRead} !== 3'b110) begin errors++; $display("FAIL store_access: got gnt/wr/rd %b want 110", {bus0.dm_gnt, bus0.MemWrite, bus0.MemRead}); end
    checks++; if ({bus0.MemAddress, bus0.WriteData} !== {32'h40, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_bus: got %h want 00000040deadbeef", {bus0.MemAddress, bus0.WriteData}); end
    bus0.dm_we = 1'b0; bus0.dm_wdata = 32'h1234_5678;
    step();
    checks++; if ({bus0.MemWrite, bus0.dm_rvalid, bus0.busy} !== 3'b000) begin errors++; $display("FAIL store_done: got wr/rvalid/busy %b want 000", {bus0.MemWrite, bus0.dm_rvalid, bus0.busy}); end
    step();
    checks++; if ({bus0.dm_gnt, bus0.MemRead, bus0.MemWrite, bus0.WriteData} !== {3'b110, 32'h0}) begin errors++; $display("FAIL load_access: got %h want 6_00000000", {bus0.dm_gnt, bus0.MemRead, bus0.MemWrite, bus0.WriteData}); end
    bus0.dm_req = 1'b0;
    step();
    checks++; if ({bus0.dm_rvalid, bus0.if_rvalid} !== 2'b10) begin errors++; $display("FAIL load_rvalid: got dm/if rvalid %b want 10", {bus0.dm_rvalid, bus0.if_rvalid}); end
    checks++; if (bus0.dm_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data: got %h want deadbeef", bus0.dm_rdata); end
    wait_idle();
  endtask

  task automatic test_priority();
    logic got0 [4];
    logic got1 [4];
    int   n0 = 0;
    int   n1 = 0;
    logic both = 1'b0;
    bus0.if_req = 1'b1; bus0.if_addr = 32'h4; bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 32'h40;
    bus1.if_req = 1'b1; bus1.if_addr = 32'h4; bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 32'h40;
    for (int c = 0; c < 20 && (n0 < 4 || n1 < 4); c++) begin
      step();
      if ((bus0.if_gnt && bus0.dm_gnt) || (bus1.if_gnt && bus1.dm_gnt)) both = 1'b1;
      if ((bus0.if_gnt || bus0.dm_gnt) && n0 < 4) begin got0[n0] = bus0.dm_gnt; n0++; end
      if ((bus1.if_gnt || bus1.dm_gnt) && n1 < 4) begin got1[n1] = bus1.dm_gnt; n1++; end
    end
    drop_reqs();
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL prio_one_gnt: got simultaneous grants %b want 0", both); end
    checks++; if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL prio_count: got %0d/%0d grants want 4/4", n0, n1); end
    for (int i = 0; i < n0; i++) begin
      logic exp_dm;
      exp_dm = (i % 2 == 1);
      checks++; if (got0[i] !== exp_dm) begin errors++; $display("FAIL rr_grant%0d: got dm=%b want dm=%b", i, got0[i], exp_dm); end
    end
    for (int i = 0; i < n1; i++) begin
      checks++; if (got1[i] !== 1'b1) begin errors++; $display("FAIL fp_grant%0d: got dm=%b want dm=1", i, got1[i]); end
    end
    wait_idle();
  endtask

  task automatic test_misaligned();
    bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 32'h42;
    step();
    checks++; if ({bus0.dm_gnt, bus0.dm_err, bus0.MemRead, bus0.MemWrite, bus0.busy} !== 5'b11001) begin errors++; $display("FAIL misalign_err: got gnt/err/rd/wr/busy %b want 11001", {bus0.dm_gnt, bus0.dm_err, bus0.MemRead, bus0.MemWrite, bus0.busy}); end
    bus0.dm_req = 1'b0;
    step();
    checks++; if ({bus0.dm_gnt, bus0.dm_err, bus0.dm_rvalid, bus0.MemRead, bus0.busy} !== 5'b00000) begin errors++; $display("FAIL misalign_after: got gnt/err/rvalid/rd/busy %b want 00000", {bus0.dm_gnt, bus0.dm_err, bus0.dm_rvalid, bus0.MemRead, bus0.busy}); end
  endtask

  task automatic test_reset_mid_access();
    bus0.if_req = 1'b1; bus0.if_addr = 32'h0;
    step();
    checks++; if ({bus0.if_gnt, bus0.MemRead} !== 2'b11) begin errors++; $display("FAIL abort_access: got gnt/rd %b want 11", {bus0.if_gnt, bus0.MemRead}); end
    reset = 1'b1; bus0.if_req = 1'b0;
    step();
    checks++; if ({bus0.if_rvalid, bus0.MemRead, bus0.busy} !== 3'b000) begin errors++; $display("FAIL abort_reset: got rvalid/rd/busy %b want 000", {bus0.if_rvalid, bus0.MemRead, bus0.busy}); end
    checks++; if (bus0.if_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h want 00000000", bus0.if_rdata); end
    reset = 1'b0;
    step();
    checks++; if ({bus0.if_rvalid, bus0.busy} !== 2'b00) begin errors++; $display("FAIL abort_quiet: got rvalid/busy %b want 00", {bus0.if_rvalid, bus0.busy}); end
    bus0.if_req = 1'b1; bus0.if_addr = 32'h4;
    step();
    checks++; if ({bus0.if_gnt, bus0.MemRead, bus0.MemAddress} !== {2'b11, 32'h4}) begin errors++; $display("FAIL abort_retry_access: got %h want 3_00000004", {bus0.if_gnt, bus0.MemRead, bus0.MemAddress}); end
    bus0.if_req = 1'b0;
    step();
    checks++; if ({bus0.if_rvalid, bus0.if_rdata} !== {1'b1, 32'h00A0_0093}) begin errors++; $display("FAIL abort_retry_data: got %h want 1_00a00093", {bus0.if_rvalid, bus0.if_rdata}); end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_store_load();
    test_priority();
    test_misaligned();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
